// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit start validation,
// centre sampling of data/stop bits, one-cycle valid or framing-error pulse.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Input_RX_Serial,
    output logic [7:0] Output_RX_Byte,
    output logic       Output_RX_Data_Valid,
    output logic       Output_RX_Framing_Error,
    output logic       Output_RX_Active,
    output logic [2:0] o_rx_state
);
    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int H  = (CLOCKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] C_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(H);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_CLEANUP   = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_clk_count;
    logic [2:0]    r_bit_index;
    logic [7:0]    r_rx_data;
    logic          w_rx_s;

    assign w_rx_s     = r_sync2;
    assign o_rx_state = r_state;

    // Idle-high line: synchronizer resets to 1 so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= Input_RX_Serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state                 <= S_IDLE;
            r_clk_count             <= '0;
            r_bit_index             <= '0;
            r_rx_data               <= '0;
            Output_RX_Byte          <= 8'h00;
            Output_RX_Data_Valid    <= 1'b0;
            Output_RX_Framing_Error <= 1'b0;
            Output_RX_Active        <= 1'b0;
        end else begin
            Output_RX_Data_Valid    <= 1'b0;
            Output_RX_Framing_Error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_count <= '0;
                    r_bit_index <= '0;
                    if (!w_rx_s) begin
                        r_state          <= S_START;
                        Output_RX_Active <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_clk_count == C_HALF) begin
                        r_clk_count <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state          <= S_IDLE;
                            Output_RX_Active <= 1'b0;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_clk_count == C_LAST) begin
                        r_clk_count            <= '0;
                        r_rx_data[r_bit_index] <= w_rx_s;
                        if (r_bit_index == 3'd7) begin
                            r_bit_index <= '0;
                            r_state     <= S_STOP;
                        end else begin
                            r_bit_index <= r_bit_index + 3'd1;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_clk_count == C_LAST) begin
                        r_clk_count      <= '0;
                        Output_RX_Active <= 1'b0;
                        if (w_rx_s) begin
                            Output_RX_Byte       <= r_rx_data;
                            Output_RX_Data_Valid <= 1'b1;
                            r_state              <= S_CLEANUP;
                        end else begin
                            Output_RX_Framing_Error <= 1'b1;
                            r_state                 <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 1'b1;
                    end
                end
                S_CLEANUP: begin
                    r_state <= S_IDLE;
                end
                // A break (line held low) must not be re-read as a new start bit.
                S_WAIT_IDLE: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_clk_count      <= '0;
                    r_bit_index      <= '0;
                    Output_RX_Active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are modelled as whole bytes
// with an expected result and arrival cycle; a monitor pops on every pulse.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int H   = (CPB - 1) / 2;
    // pin change -> 2 sync edges -> IDLE sees it (t0) -> stop sample at t0+1+H+9*CPB
    localparam int START_SEEN = 3;
    localparam int PULSE_LAT  = START_SEEN + 1 + H + 9 * CPB;

    logic       clk;
    logic       rst;
    logic       rx_pin;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_active;
    logic [2:0] rx_state;

    uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .Input_RX_Serial         (rx_pin),
        .Output_RX_Byte          (rx_byte),
        .Output_RX_Data_Valid    (rx_valid),
        .Output_RX_Framing_Error (rx_ferr),
        .Output_RX_Active        (rx_active),
        .o_rx_state              (rx_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];      // {framing_error, byte}
    int         exp_cyc_q[$];
    logic [7:0] model_byte = 8'h00;
    int n_checks = 0;
    int n_pass   = 0;
    int active_rise = -1;
    int active_fall = -1;
    int last_start  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1;
        exp_q.push_back(stop_bit ? {1'b0, b} : {1'b1, model_byte});
        exp_cyc_q.push_back(cyc + PULSE_LAT);
        if (stop_bit) model_byte = b;
        last_start = cyc;
        rx_pin = 1'b0;
        for (int i = 0; i < 9; i++) begin
            repeat (CPB) @(posedge clk);
            #1;
            rx_pin = (i < 8) ? b[i] : stop_bit;
        end
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic hold_line(input logic level, input int cycles);
        @(posedge clk); #1;
        rx_pin = level;
        repeat (cycles - 1) @(posedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_byte"}, rx_byte, 8'h00);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_ferr"}, rx_ferr, 0);
        check({tag, "_active"}, rx_active, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic       prev_pulse;
        logic       prev_active;
        logic [8:0] e;
        int         t;
        prev_pulse  = 1'b0;
        prev_active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pulse  = 1'b0;
                prev_active = 1'b0;
            end else begin
                if (rx_active && !prev_active) active_rise = cyc;
                if (!rx_active && prev_active) active_fall = cyc;
                prev_active = rx_active;
                if (rx_valid || rx_ferr) begin
                    check("mutual_excl", rx_valid && rx_ferr, 0);
                    check("no_adjacent_pulse", prev_pulse, 0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b byte=%0h with nothing expected (cycle %0d)",
                                 rx_valid, rx_ferr, rx_byte, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        t = exp_cyc_q.pop_front();
                        check("pulse_kind_ferr", rx_ferr, e[8]);
                        check("rx_byte", rx_byte, e[7:0]);
                        check("pulse_cycle", cyc, t);
                    end
                end
                prev_pulse = rx_valid || rx_ferr;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        logic [7:0] b;
        logic       sb;
        rst    = 1'b1;
        rx_pin = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_idle_outputs("reset");

        // single frame with latency and active window
        hold_line(1'b1, 10);
        send_frame(8'h55, 1'b1);
        s = last_start;
        wait_drain();
        check("active_rise_55", active_rise, s + START_SEEN);
        check("active_fall_55", active_fall, s + PULSE_LAT);

        // back-to-back frames, single stop bit each
        hold_line(1'b1, 5);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_drain();

        // short low glitch is rejected
        hold_line(1'b1, 2 * CPB);
        @(posedge clk); #1;
        s = cyc;
        rx_pin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        check("glitch_active_rise", active_rise, s + START_SEEN);
        check("glitch_active_fall", active_fall, s + START_SEEN + 1 + H);
        check("glitch_no_pending", exp_q.size(), 0);
        send_frame(8'h0F, 1'b1);
        wait_drain();

        // framing error followed by a break, then a good frame
        hold_line(1'b1, CPB);
        send_frame(8'h81, 1'b0);
        hold_line(1'b0, 50);
        check("break_state_active", rx_active, 0);
        hold_line(1'b1, 2 * CPB);
        send_frame(8'h7E, 1'b1);
        wait_drain();

        // asynchronous reset during data bit 3 of 0xF0
        hold_line(1'b1, CPB);
        @(posedge clk); #1;
        rx_pin = 1'b0;
        repeat (CPB + 3 * CPB + CPB / 2) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_idle_outputs("async_reset");
        model_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold_line(1'b1, 2 * CPB);
        check_idle_outputs("after_reset");
        send_frame(8'hC3, 1'b1);
        wait_drain();

        // randomized frames with random gaps and occasional bad stop bits
        for (int k = 0; k < 24; k++) begin
            b  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 4) != 0);
            send_frame(b, sb);
            if (!sb) begin
                hold_line(1'b0, $urandom_range(1, 30));
                hold_line(1'b1, $urandom_range(2, 10));
            end else if ($urandom_range(0, 1) == 1) begin
                hold_line(1'b1, $urandom_range(1, 20));
            end
        end
        hold_line(1'b1, 4);
        wait_drain();
        repeat (2 * CPB) @(posedge clk);
        check("final_active", rx_active, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
